modulo_updown_counter: RTL and testbench
========================================

MODULO_UPDOWN_COUNTER -- requirements
Module: modulo_updown_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 5, which sets the counter width in bits; legal values are 2..16.
REQ-002 The module SHALL have parameter MAX_COUNT, default 2**WIDTH-1, which sets the top of the count range 0..MAX_COUNT; legal values are 1..2**WIDTH-1.
REQ-003 The module SHALL have port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst: input, 1 bit, synchronous active-high reset.
REQ-005 The module SHALL have port enable: input, 1 bit; 1 = count this cycle.
REQ-006 The module SHALL have port up_down: input, 1 bit; 1 = count up, 0 = count down.
REQ-007 The module SHALL have port load: input, 1 bit, synchronous parallel-load strobe.
REQ-008 The module SHALL have port e_load: input, WIDTH bits, the parallel-load value.
REQ-009 The module SHALL have port q: output, WIDTH bits, the registered count.
REQ-010 The module SHALL have port tc: output, 1 bit, combinational terminal count.
REQ-011 The module SHALL have port wrap: output, 1 bit, registered one-cycle boundary-event pulse.

Function
REQ-012 Per-edge priority SHALL be rst > load > enable > hold.
REQ-013 On load, q SHALL take min(e_load, MAX_COUNT) at the next edge, independent of enable and up_down.
REQ-014 With enable=1, up_down=1 and q<MAX_COUNT, q SHALL increment by 1; with up_down=0 and q>0, q SHALL decrement by 1.
REQ-015 Count up at q==MAX_COUNT SHALL load 0 (wrap); count down at q==0 SHALL load MAX_COUNT (wrap), subject to REQ-024.
REQ-016 With enable=0 and load=0, q SHALL hold its value.
REQ-017 tc SHALL be 1 iff enable=1 and load=0 and ((up_down=1 and q==MAX_COUNT) or (up_down=0 and q==0)); otherwise 0.
REQ-018 wrap SHALL be 1 for exactly the one cycle after an edge at which tc was 1, and 0 otherwise.
REQ-019 A change of up_down while enabled SHALL take effect on the next edge with no dead cycle.
REQ-020 If q has a value above MAX_COUNT, the next enabled up-count SHALL go to 0 and the next enabled down-count SHALL go to MAX_COUNT.
REQ-021 Count latency SHALL be one clock edge from enable to the updated q; there is no pipelining.

Reset
REQ-022 While rst=1 at an edge, q SHALL become 0 and wrap SHALL become 0, overriding load and enable.
REQ-023 rst asserted mid-count SHALL lose no cycle: counting SHALL resume on the first edge with rst=0 and enable=1, starting from 0.

Configuration
REQ-024 With macro MODULO_COUNTER_SATURATE_EN defined, the count SHALL saturate instead of wrapping:
- Up at MAX_COUNT holds MAX_COUNT; down at 0 holds 0.
- tc SHALL still assert per REQ-017.
- wrap SHALL stay constant 0.
Without the macro, wrap behaviour per REQ-015 and REQ-018 SHALL apply.

Verification (WIDTH=5, MAX_COUNT=23)
REQ-025 Reset, then enable=1, up_down=1 for 25 cycles -> q steps 0..23, then 0; tc=1 only while q==23; wrap=1 on the cycle q==0 after 23.
REQ-026 load=1, e_load=5, then up_down=0, enable=1 for 7 cycles -> q=5,4,3,2,1,0,23,22; wrap pulses once after the 0->23 step.
REQ-027 load=1 with e_load=30 -> q=23; load=1 together with enable=1, up_down=1, e_load=7 -> q=7, no increment that edge.
REQ-028 At q=10 counting up, assert rst=1 together with load=1, e_load=3 for one cycle -> q=0, wrap=0; next enabled edge -> q=1.
REQ-029 With MODULO_COUNTER_SATURATE_EN defined, at q=23 up for 3 cycles -> q stays 23, tc=1, wrap=0; at q=0 down -> q stays 0.
REQ-030 Toggle up_down every cycle with enable=1 from q=12 -> q alternates 13,12,13,12; enable=0 -> q frozen.

Source files
------------

// File: rtl/modulo_updown_counter.sv
// Modulo-(MAX_COUNT+1) up/down counter with parallel load, terminal count and wrap pulse.
// Define MODULO_COUNTER_SATURATE_EN to make the count saturate at its ends instead of wrapping.
module modulo_updown_counter #(
  parameter int WIDTH     = 5,
  parameter int MAX_COUNT = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] e_load,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO  = '0;

`ifdef MODULO_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_END_V = MAX_V;
  localparam logic [WIDTH-1:0] DN_END_V = ZERO;
`else
  localparam logic [WIDTH-1:0] UP_END_V = ZERO;
  localparam logic [WIDTH-1:0] DN_END_V = MAX_V;
`endif

  logic [WIDTH-1:0] count_q, count_d, load_val;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero, over_max, tc_c;

  // A full-range counter can never exceed MAX_COUNT, so skip the compares there.
  generate
    if (MAX_COUNT == (2**WIDTH)-1) begin : g_full
      assign over_max = 1'b0;
      assign load_val = e_load;
    end else begin : g_part
      assign over_max = (count_q > MAX_V);
      assign load_val = (e_load > MAX_V) ? MAX_V : e_load;
    end
  endgenerate

  assign at_max  = (count_q == MAX_V);
  assign at_zero = (count_q == ZERO);
  assign tc_c    = enable & ~load & (up_down ? at_max : at_zero);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (enable) begin
      if (up_down) begin
        if (over_max)    count_d = ZERO;
        else if (at_max) count_d = UP_END_V;
        else             count_d = count_q + ONE;
      end else begin
        if (over_max)     count_d = MAX_V;
        else if (at_zero) count_d = DN_END_V;
        else              count_d = count_q - ONE;
      end
    end
  end

`ifdef MODULO_COUNTER_SATURATE_EN
  assign wrap_d = 1'b0;
`else
  assign wrap_d = tc_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= ZERO;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = count_q;
  assign tc   = tc_c;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Scoreboard bench for modulo_updown_counter at WIDTH=5, MAX_COUNT=23.
module tb_modulo_updown_counter;

  localparam int W   = 5;
  localparam int MAX = 23;

  logic         clk = 1'b0;
  logic         rst, enable, up_down, load;
  logic [W-1:0] e_load;
  logic [W-1:0] q;
  logic         tc, wrap;

  typedef struct {
    logic [W-1:0] q;
    logic         w;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mq     = 0;   // bench model of the count

  modulo_updown_counter #(.WIDTH(W), .MAX_COUNT(MAX)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down),
    .load(load), .e_load(e_load), .q(q), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle, check tc combinationally, push expected post-edge state, then pop and compare.
  task automatic step(input logic r, input logic ld, input int el, input logic en, input logic ud);
    exp_t e;
    int   ld_v;
    logic mtc;
    @(negedge clk);
    rst = r; load = ld; e_load = W'(el); enable = en; up_down = ud;
    #1;
    mtc = en && !ld && ((ud && mq == MAX) || (!ud && mq == 0));
    chk("tc", tc, mtc);
    ld_v = (el > MAX) ? MAX : el;
    e.w = 1'b0;
    if (r) mq = 0;
    else if (ld) mq = ld_v;
    else if (en) begin
`ifdef MODULO_COUNTER_SATURATE_EN
      if (ud) mq = (mq >= MAX) ? MAX : mq + 1;
      else    mq = (mq == 0) ? 0 : mq - 1;
`else
      if (ud) mq = (mq >= MAX) ? 0 : mq + 1;
      else    mq = (mq == 0) ? MAX : mq - 1;
      e.w = mtc;
`endif
    end
    e.q = W'(mq);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("q", q, e.q);
    chk("wrap", wrap, e.w);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; e_load = '0; enable = 1'b0; up_down = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 1, 9, 1, 1);
    chk("reset_q", q, 0);
    chk("reset_wrap", wrap, 0);

    // full up sweep through the wrap
    for (int i = 0; i < 25; i++) step(0, 0, 0, 1, 1);
`ifndef MODULO_COUNTER_SATURATE_EN
    chk("sweep_end", q, 1);
`endif

    // load 5, count down through 0
    step(0, 1, 5, 0, 0);
    chk("load5", q, 5);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
`ifndef MODULO_COUNTER_SATURATE_EN
    chk("down_wrap_end", q, 22);
`endif

    // clamp and load priority over enable
    step(0, 1, 30, 0, 0);
    chk("clamp", q, 23);
    step(0, 1, 7, 1, 1);
    chk("load_over_en", q, 7);
    step(0, 1, 31, 1, 0);

    // reset overrides load mid-count
    step(0, 1, 9, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("at10", q, 10);
    step(1, 1, 3, 1, 1);
    chk("rst_over_load", q, 0);
    step(0, 0, 0, 1, 1);
    chk("resume", q, 1);

    // direction toggling then freeze
    step(0, 1, 12, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, (i % 2 == 0));
    chk("toggle_end", q, 12);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, i[0]);
    chk("frozen", q, 12);

    // ends of range, up at top and down at bottom
    step(0, 1, 23, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0);

    // random traffic, loads include out-of-range values
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
